// File: rtl/paddle_collide.sv
// paddle_collide: registered paddle-collision classifier for the Pong datapath.
// Optional hit counters are compiled in when PCOLL_HITCNT_EN is defined.
module paddle_collide #(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int LEFT_X    = 40,
  parameter int RIGHT_X   = 120,
  parameter int PADDLE_H  = 8,
  parameter int ZONE_T    = 3,
  parameter int BALL_YOFF = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             gameStart,
  input  logic             enable,
  input  logic [Y_W-1:0]   yLeftPaddleCoordIn,
  input  logic [Y_W-1:0]   yRightPaddleCoordIn,
  input  logic [X_W-1:0]   xBallCoordIn,
  input  logic [Y_W-1:0]   yBallCoordIn,
  output logic [2:0]       PCollOut,
  output logic             PCollInner,
  output logic             PCollDone,
`ifdef PCOLL_HITCNT_EN
  output logic [CNT_W-1:0] hitCountLeft,
  output logic [CNT_W-1:0] hitCountRight,
`endif
  output logic             PCollBusy
);

  localparam int DW = Y_W + 2;

  typedef logic signed [DW-1:0] off_t;

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    REPORT
  } state_t;

  localparam off_t YOFF = off_t'(BALL_YOFF);
  localparam off_t H    = off_t'(PADDLE_H);
  localparam off_t H1   = off_t'(PADDLE_H - 1);
  localparam off_t ONE  = off_t'(1);
  localparam off_t ZT   = off_t'(ZONE_T);
  localparam off_t ZB   = off_t'(PADDLE_H - ZONE_T);

  localparam logic [X_W-1:0] L_BACK = X_W'(LEFT_X - 1);
  localparam logic [X_W-1:0] L_MID  = X_W'(LEFT_X);
  localparam logic [X_W-1:0] L_FACE = X_W'(LEFT_X + 1);
  localparam logic [X_W-1:0] R_FACE = X_W'(RIGHT_X - 1);
  localparam logic [X_W-1:0] R_MID  = X_W'(RIGHT_X);
  localparam logic [X_W-1:0] R_BACK = X_W'(RIGHT_X + 1);

  state_t         state;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] yb_q;
  logic [Y_W-1:0] yl_q;
  logic [Y_W-1:0] yr_q;
  logic           lock_l;
  logic           lock_r;

  off_t       d_l;
  off_t       d_r;
  logic       hit_l;
  logic       hit_r;
  logic       inner_l;
  logic       inner_r;
  logic       win_l;
  logic       win_r;
  logic       take_l;
  logic       take_r;
  logic [2:0] code_l;
  logic [2:0] code_r;

  function automatic logic in_span(off_t d);
    return !d[DW-1] && (d <= H);
  endfunction

  function automatic logic at_end(off_t d);
    return (d == '0) || (d == H);
  endfunction

  function automatic logic near_end(off_t d);
    return (d == ONE) || (d == H1);
  endfunction

  function automatic logic [2:0] zone(
    off_t d, logic [2:0] top, logic [2:0] mid, logic [2:0] bot
  );
    if (d < ZT) return top;
    if (d > ZB) return bot;
    return mid;
  endfunction

  // Extended, signed offsets so a large ball y cannot wrap into range.
  assign d_l = off_t'({2'b00, yb_q}) + YOFF - off_t'({2'b00, yl_q});
  assign d_r = off_t'({2'b00, yb_q}) + YOFF - off_t'({2'b00, yr_q});

  assign win_l  = x_q inside {L_BACK, L_MID, L_FACE};
  assign win_r  = x_q inside {R_BACK, R_MID, R_FACE};
  assign code_l = zone(d_l, 3'b001, 3'b110, 3'b101);
  assign code_r = zone(d_r, 3'b010, 3'b011, 3'b100);
  assign take_l = hit_l && !lock_l;
  assign take_r = hit_r && !lock_r && !take_l;

  // Column decode: face, middle and back contact rules per paddle.
  always_comb begin
    hit_l   = 1'b0;
    hit_r   = 1'b0;
    inner_l = 1'b0;
    inner_r = 1'b0;
    unique case (1'b1)
      (x_q == L_FACE): hit_l = in_span(d_l);
      (x_q == L_MID): begin
        hit_l   = in_span(d_l);
        inner_l = in_span(d_l) && !at_end(d_l);
      end
      (x_q == L_BACK): begin
        hit_l   = at_end(d_l) || near_end(d_l);
        inner_l = near_end(d_l);
      end
      (x_q == R_FACE): hit_r = in_span(d_r);
      (x_q == R_MID): begin
        hit_r   = in_span(d_r);
        inner_r = in_span(d_r) && !at_end(d_r);
      end
      (x_q == R_BACK): begin
        hit_r   = at_end(d_r) || near_end(d_r);
        inner_r = near_end(d_r);
      end
      default: ;
    endcase
  end

  // Request FSM: capture, wait, report with lockout bookkeeping.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      state      <= IDLE;
      x_q        <= '0;
      yb_q       <= '0;
      yl_q       <= '0;
      yr_q       <= '0;
      lock_l     <= 1'b0;
      lock_r     <= 1'b0;
      PCollOut   <= 3'b000;
      PCollInner <= 1'b0;
      PCollDone  <= 1'b0;
      PCollBusy  <= 1'b0;
    end else if (gameStart) begin
      state      <= IDLE;
      lock_l     <= 1'b0;
      lock_r     <= 1'b0;
      PCollOut   <= 3'b000;
      PCollInner <= 1'b0;
      PCollDone  <= 1'b0;
      PCollBusy  <= 1'b0;
    end else begin
      PCollDone <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            x_q       <= xBallCoordIn;
            yb_q      <= yBallCoordIn;
            yl_q      <= yLeftPaddleCoordIn;
            yr_q      <= yRightPaddleCoordIn;
            state     <= CAPT;
            PCollBusy <= 1'b1;
          end
        end
        CAPT: state <= REPORT;
        REPORT: begin
          state     <= IDLE;
          PCollBusy <= 1'b0;
          PCollDone <= 1'b1;
          if (take_l) begin
            PCollOut   <= code_l;
            PCollInner <= inner_l;
            lock_l     <= 1'b1;
          end else if (take_r) begin
            PCollOut   <= code_r;
            PCollInner <= inner_r;
            lock_r     <= 1'b1;
          end else begin
            PCollOut   <= 3'b000;
            PCollInner <= 1'b0;
          end
          if (!win_l) lock_l <= 1'b0;
          if (!win_r) lock_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PCOLL_HITCNT_EN
  localparam logic [CNT_W-1:0] CMAX = '1;

  // Saturating per-side counts of reported (unlocked) hits.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      hitCountLeft  <= '0;
      hitCountRight <= '0;
    end else if (gameStart) begin
      hitCountLeft  <= '0;
      hitCountRight <= '0;
    end else if (state == REPORT) begin
      if (take_l && hitCountLeft != CMAX)
        hitCountLeft <= hitCountLeft + 1'b1;
      if (take_r && hitCountRight != CMAX)
        hitCountRight <= hitCountRight + 1'b1;
    end
  end
`else
  // Hit counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_paddle_collide.sv
// tb_paddle_collide: scoreboard bench for paddle_collide.
// Directed cases plus randomized requests against a behavioural model.
module tb_paddle_collide;

  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int LEFT_X    = 40;
  localparam int RIGHT_X   = 120;
  localparam int PADDLE_H  = 8;
  localparam int ZONE_T    = 3;
  localparam int BALL_YOFF = 2;
  localparam int CNT_W     = 2;
  localparam int CMAX      = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             resetn;
  logic             gameStart;
  logic             enable;
  logic [Y_W-1:0]   yl;
  logic [Y_W-1:0]   yr;
  logic [X_W-1:0]   xb;
  logic [Y_W-1:0]   yb;
  logic [2:0]       pout;
  logic             pinner;
  logic             pdone;
  logic             pbusy;
`ifdef PCOLL_HITCNT_EN
  logic [CNT_W-1:0] cnt_left;
  logic [CNT_W-1:0] cnt_right;
`endif

  paddle_collide #(
    .X_W(X_W), .Y_W(Y_W), .LEFT_X(LEFT_X), .RIGHT_X(RIGHT_X),
    .PADDLE_H(PADDLE_H), .ZONE_T(ZONE_T), .BALL_YOFF(BALL_YOFF),
    .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .gameStart(gameStart),
    .enable(enable),
    .yLeftPaddleCoordIn(yl),
    .yRightPaddleCoordIn(yr),
    .xBallCoordIn(xb),
    .yBallCoordIn(yb),
    .PCollOut(pout),
    .PCollInner(pinner),
    .PCollDone(pdone),
`ifdef PCOLL_HITCNT_EN
    .hitCountLeft(cnt_left),
    .hitCountRight(cnt_right),
`endif
    .PCollBusy(pbusy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int code;
    int inner;
    int cl;
    int cr;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   m_lock_l;
  bit   m_lock_r;
  int   m_cnt_l;
  int   m_cnt_r;

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Contact rule for one paddle; dx = +1 face, 0 middle, -1 back.
  function automatic void contact(int dx, int d, output bit hit, output bit inner);
    hit   = 0;
    inner = 0;
    if (d < 0 || d > PADDLE_H) return;
    if (dx == 1) hit = 1;
    else if (dx == 0) begin
      hit   = 1;
      inner = (d != 0 && d != PADDLE_H);
    end else if (dx == -1) begin
      inner = (d == 1 || d == PADDLE_H - 1);
      hit   = inner || d == 0 || d == PADDLE_H;
    end
  endfunction

  function automatic int zone_idx(int d);
    if (d < ZONE_T) return 0;
    if (d > PADDLE_H - ZONE_T) return 2;
    return 1;
  endfunction

  function automatic void model_clear();
    m_lock_l = 0;
    m_lock_r = 0;
    m_cnt_l  = 0;
    m_cnt_r  = 0;
  endfunction

  function automatic void model_req(int x, int ybv, int ylv, int yrv);
    int   left_codes[3]  = '{1, 6, 5};
    int   right_codes[3] = '{2, 3, 4};
    int   dxl = x - LEFT_X;
    int   dxr = RIGHT_X - x;
    int   dl  = ybv + BALL_YOFF - ylv;
    int   dr  = ybv + BALL_YOFF - yrv;
    bit   hl, il, hr, ir;
    exp_t e;
    contact(dxl, dl, hl, il);
    contact(dxr, dr, hr, ir);
    e.code  = 0;
    e.inner = 0;
    if (hl && !m_lock_l) begin
      e.code   = left_codes[zone_idx(dl)];
      e.inner  = int'(il);
      m_lock_l = 1;
      if (m_cnt_l < CMAX) m_cnt_l++;
    end else if (hr && !m_lock_r) begin
      e.code   = right_codes[zone_idx(dr)];
      e.inner  = int'(ir);
      m_lock_r = 1;
      if (m_cnt_r < CMAX) m_cnt_r++;
    end
    if (dxl < -1 || dxl > 1) m_lock_l = 0;
    if (dxr < -1 || dxr > 1) m_lock_r = 0;
    e.cl = m_cnt_l;
    e.cr = m_cnt_r;
    sb.push_back(e);
  endfunction

  function automatic void drive(int x, int ybv, int ylv, int yrv);
    xb = X_W'(x);
    yb = Y_W'(ybv);
    yl = Y_W'(ylv);
    yr = Y_W'(yrv);
  endfunction

  // abort: 0 none, 1 gameStart in CAPT, 2 reset in CAPT, 3 gameStart with enable
  task automatic req(int x, int ybv, int ylv, int yrv, int abort);
    @(negedge clock);
    drive(x, ybv, ylv, yrv);
    enable = 1'b1;
    if (abort == 3) begin
      gameStart = 1'b1;
      @(negedge clock);
      enable    = 1'b0;
      gameStart = 1'b0;
      model_clear();
      check("drop_busy", int'(pbusy), 0);
      check("drop_out", int'(pout), 0);
      return;
    end
    if (abort == 0) model_req(x, ybv, ylv, yrv);
    @(negedge clock);
    enable = 1'b0;
    check("capt_done", int'(pdone), 0);
    check("capt_busy", int'(pbusy), 1);
    if (abort != 0) begin
      if (abort == 1) gameStart = 1'b1;
      else resetn = 1'b1;
      @(negedge clock);
      gameStart = 1'b0;
      resetn    = 1'b0;
      model_clear();
      check("abort_busy", int'(pbusy), 0);
      check("abort_done", int'(pdone), 0);
      check("abort_out", int'(pout), 0);
      @(negedge clock);
      check("abort_nodone", int'(pdone), 0);
      return;
    end
    @(negedge clock);
    check("rep_done", int'(pdone), 0);
    check("rep_busy", int'(pbusy), 1);
    @(negedge clock);
    check("done_pulse", int'(pdone), 1);
    check("done_busy", int'(pbusy), 0);
  endtask

  initial begin
    resetn    = 1'b1;
    gameStart = 1'b0;
    enable    = 1'b0;
    drive(0, 0, 0, 0);
    model_clear();

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clock);
          if (pdone === 1'b1) begin
            if (sb.size() == 0) check("spurious_done", 1, 0);
            else begin
              e = sb.pop_front();
              check("code", int'(pout), e.code);
              check("inner", int'(pinner), e.inner);
`ifdef PCOLL_HITCNT_EN
              check("cnt_left", int'(cnt_left), e.cl);
              check("cnt_right", int'(cnt_right), e.cr);
`endif
            end
          end
        end
      end
      begin : watchdog
        #2000000;
        $display("FAIL watchdog: run did not finish, %0d pending", sb.size());
        $fatal(1, "timeout");
      end
    join_none

    repeat (2) @(negedge clock);
    check("rst_out", int'(pout), 0);
    check("rst_inner", int'(pinner), 0);
    check("rst_done", int'(pdone), 0);
    check("rst_busy", int'(pbusy), 0);
`ifdef PCOLL_HITCNT_EN
    check("rst_cnt_l", int'(cnt_left), 0);
    check("rst_cnt_r", int'(cnt_right), 0);
`endif
    resetn = 1'b0;

    // face hit, inner contact, back miss
    req(41, 21, 20, 0, 0);
    req(120, 49, 0, 50, 0);
    req(121, 51, 0, 50, 0);
    // lockout sequence
    req(41, 18, 20, 0, 0);
    req(41, 18, 20, 0, 0);
    req(60, 18, 20, 0, 0);
    req(41, 18, 20, 0, 0);
    // no false hit from wrap
    req(40, 125, 0, 0, 0);
    req(120, 125, 0, 0, 0);
    // aborts clear locks and drop the request
    req(41, 18, 20, 0, 0);
    req(41, 18, 20, 0, 1);
    req(41, 18, 20, 0, 0);
    req(41, 18, 20, 0, 3);
    req(41, 18, 20, 0, 0);
    req(41, 18, 20, 0, 2);
    req(41, 18, 20, 0, 0);

    // enable held high: accepted every third cycle
    @(negedge clock);
    drive(41, 18, 20, 0);
    enable = 1'b1;
    repeat (3) model_req(41, 18, 20, 0);
    repeat (7) @(negedge clock);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    check("held_pending", sb.size(), 0);

    // counter saturation on the left side
    repeat (5) begin
      req(60, 10, 20, 0, 0);
      req(41, 20, 20, 0, 0);
    end

    // randomized requests
    repeat (300) begin
      int r, x, ylv, yrv, yp, t, ab;
      r = int'($urandom_range(0, 9));
      if (r < 4) x = LEFT_X - 2 + int'($urandom_range(0, 4));
      else if (r < 8) x = RIGHT_X - 2 + int'($urandom_range(0, 4));
      else x = int'($urandom_range(0, 255));
      ylv = int'($urandom_range(0, 127));
      yrv = int'($urandom_range(0, 127));
      yp  = (x < 80) ? ylv : yrv;
      t   = yp - BALL_YOFF + int'($urandom_range(0, 14)) - 3;
      if (t < 0 || t > 127) t = int'($urandom_range(0, 127));
      ab = ($urandom_range(0, 24) == 0) ? int'($urandom_range(1, 3)) : 0;
      req(x, t, ylv, yrv, ab);
    end

    repeat (6) @(negedge clock);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
